div_bcd_out: RTL

DIV_BCD_OUT -- requirements
Module: div_bcd_out

---
 rtl/div_pkg.sv | 17 +
 rtl/bcd_adj3.sv | 9 +
 rtl/div_bcd_out.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths, shift count and FSM encoding for the divider-result BCD converter.
package div_pkg;

  localparam int QW        = 8;
  localparam int RW        = 7;
  localparam int BCD_W     = 12;
  localparam int NDIG      = BCD_W / 4;
  localparam int SHIFT_CNT = 8;
  localparam int CNT_W     = $clog2(SHIFT_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: one BCD digit, add 3 when the digit is 5 or more.
module bcd_adj3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/div_bcd_out.sv
// Converts a divider's quotient/remainder to 3-digit BCD by serial double-dabble.
// Remainder conversion is built only when DIV_BCD_REM_EN is defined; otherwise r_bcd reads 0.
module div_bcd_out
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [QW-1:0]    quotient,
  input  logic [RW-1:0]    remainder,
  input  logic             valid,
  input  logic             ack,
  output logic [BCD_W-1:0] q_bcd,
  output logic [BCD_W-1:0] r_bcd,
  output logic             busy,
  output logic             done,
  output logic             missed
);

  state_t           state_q, state_d;
  logic             valid_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             missed_q, missed_d;
  logic             capture;
  logic             load_ops;
  logic             shift_en;
  logic             finish;

  logic [QW-1:0]    q_bin_q, q_bin_d;
  logic [BCD_W-1:0] q_acc_q, q_acc_d;
  logic [BCD_W-1:0] q_bcd_q, q_bcd_d;
  logic [BCD_W-1:0] q_adj;
  logic [BCD_W-1:0] q_shift;

  // A level-high valid produces a single capture on its rising edge.
  assign capture = valid & ~valid_dly_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;
    load_ops = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load_ops = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (capture) begin
          missed_d = 1'b1;
        end
        if (cnt_q == CNT_W'(SHIFT_CNT - 1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (capture) begin
          load_ops = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else if (ack) begin
          missed_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_q_adj
    bcd_adj3 u_q_adj (
      .digit_i (q_acc_q[gi*4 +: 4]),
      .digit_o (q_adj[gi*4 +: 4])
    );
  end

  assign q_shift = {q_adj[BCD_W-2:0], q_bin_q[QW-1]};

  // Visible result changes only when a conversion completes.
  always_comb begin
    q_bin_d = q_bin_q;
    q_acc_d = q_acc_q;
    q_bcd_d = q_bcd_q;
    if (load_ops) begin
      q_bin_d = quotient;
      q_acc_d = '0;
    end else if (shift_en) begin
      q_bin_d = {q_bin_q[QW-2:0], 1'b0};
      q_acc_d = q_shift;
      if (finish) begin
        q_bcd_d = q_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_dly_q <= 1'b0;
      cnt_q       <= '0;
      missed_q    <= 1'b0;
      q_bin_q     <= '0;
      q_acc_q     <= '0;
      q_bcd_q     <= '0;
    end else begin
      state_q     <= state_d;
      valid_dly_q <= valid;
      cnt_q       <= cnt_d;
      missed_q    <= missed_d;
      q_bin_q     <= q_bin_d;
      q_acc_q     <= q_acc_d;
      q_bcd_q     <= q_bcd_d;
    end
  end

`ifdef DIV_BCD_REM_EN
  logic [QW-1:0]    r_bin_q, r_bin_d;
  logic [BCD_W-1:0] r_acc_q, r_acc_d;
  logic [BCD_W-1:0] r_bcd_q, r_bcd_d;
  logic [BCD_W-1:0] r_adj;
  logic [BCD_W-1:0] r_shift;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_r_adj
    bcd_adj3 u_r_adj (
      .digit_i (r_acc_q[gi*4 +: 4]),
      .digit_o (r_adj[gi*4 +: 4])
    );
  end

  assign r_shift = {r_adj[BCD_W-2:0], r_bin_q[QW-1]};

  always_comb begin
    r_bin_d = r_bin_q;
    r_acc_d = r_acc_q;
    r_bcd_d = r_bcd_q;
    if (load_ops) begin
      r_bin_d = {{(QW-RW){1'b0}}, remainder};
      r_acc_d = '0;
    end else if (shift_en) begin
      r_bin_d = {r_bin_q[QW-2:0], 1'b0};
      r_acc_d = r_shift;
      if (finish) begin
        r_bcd_d = r_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin_q <= '0;
      r_acc_q <= '0;
      r_bcd_q <= '0;
    end else begin
      r_bin_q <= r_bin_d;
      r_acc_q <= r_acc_d;
      r_bcd_q <= r_bcd_d;
    end
  end

  assign r_bcd = r_bcd_q;
`else
  logic unused_rem;
  assign unused_rem = ^remainder;
  assign r_bcd      = '0;
`endif

  assign q_bcd  = q_bcd_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign missed = missed_q;

endmodule
